// File: rtl/conv_coef_ctrl.sv
// Coefficient bank controller for the 5x5 convolution path: host writes fill a
// pending bank that is copied to the active bank only at the next frame start.
module conv_coef_ctrl #(
  parameter int unsigned N_TAPS  = 25,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned SHIFT_W = 4,
  parameter bit          VS_POL  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_vs,
  input  logic                       cfg_we,
  input  logic                       cfg_re,
  input  logic [4:0]                 cfg_addr,
  input  logic [COEF_W-1:0]          cfg_wdata,
  output logic [COEF_W-1:0]          cfg_rdata,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  output logic                       armed,
  output logic [N_TAPS*COEF_W-1:0]   coef_act,
  output logic [SHIFT_W-1:0]         shift_act,
  output logic                       coef_upd
);

  typedef enum logic [1:0] {IDLE, ARMED, SWAP} state_t;

  localparam logic [4:0]         ADDR_SHIFT = 5'(N_TAPS);
  localparam logic [4:0]         ADDR_CTRL  = 5'(N_TAPS + 1);
  localparam int unsigned        ID_TAP     = N_TAPS / 2;
  localparam logic [COEF_W-1:0]  ID_COEF    = COEF_W'(16);
  localparam logic [SHIFT_W-1:0] ID_SHIFT   = SHIFT_W'(4);

  state_t              state, state_nx;
  logic                vs_d;
  logic [COEF_W-1:0]   pend_coef [N_TAPS];
  logic [COEF_W-1:0]   act_coef  [N_TAPS];
  logic [SHIFT_W-1:0]  pend_shift;

  logic vs_edge, wr_tap, wr_shift, wr_ctrl, wr_rsvd, commit, abort;

  assign vs_edge  = (rx_vs == VS_POL) && (vs_d != VS_POL);
  assign wr_tap   = cfg_we && (cfg_addr < ADDR_SHIFT);
  assign wr_shift = cfg_we && (cfg_addr == ADDR_SHIFT);
  assign wr_ctrl  = cfg_we && (cfg_addr == ADDR_CTRL);
  assign wr_rsvd  = cfg_we && (cfg_addr > ADDR_CTRL);
  assign commit   = wr_ctrl && cfg_wdata[0];
  assign abort    = wr_ctrl && cfg_wdata[1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      vs_d  <= ~VS_POL;
    end else begin
      state <= state_nx;
      vs_d  <= rx_vs;
    end
  end

  // A commit landing in IDLE never sees the current edge, so it always waits
  // for the following frame start.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (commit) state_nx = ARMED;
      ARMED:   if (abort) state_nx = IDLE;
               else if (vs_edge) state_nx = SWAP;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    armed     = (state == ARMED);
  end

  // NOTE: both banks are small register files that must come out of reset as
  // the identity kernel, so they are reset explicitly rather than left as RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        pend_coef[i] <= (i == ID_TAP) ? ID_COEF : '0;
        act_coef[i]  <= (i == ID_TAP) ? ID_COEF : '0;
      end
      pend_shift <= ID_SHIFT;
      shift_act  <= ID_SHIFT;
    end else begin
      if (state == IDLE && wr_tap)   pend_coef[cfg_addr] <= cfg_wdata;
      if (state == IDLE && wr_shift) pend_shift <= cfg_wdata[SHIFT_W-1:0];
      if (state == SWAP) begin
        act_coef  <= pend_coef;
        shift_act <= pend_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
      coef_upd  <= 1'b0;
    end else begin
      coef_upd <= (state == SWAP);
      cfg_err  <= wr_rsvd || ((wr_tap || wr_shift) && state != IDLE);
      if (cfg_re) begin
        if (cfg_addr < ADDR_SHIFT)       cfg_rdata <= pend_coef[cfg_addr];
        else if (cfg_addr == ADDR_SHIFT) cfg_rdata <= {{(COEF_W-SHIFT_W){1'b0}}, pend_shift};
        else if (cfg_addr == ADDR_CTRL)  cfg_rdata <= {(state == ARMED), {(COEF_W-1){1'b0}}};
        else                             cfg_rdata <= '0;
      end
    end
  end

  always_comb begin
    coef_act = '0;
    for (int i = 0; i < N_TAPS; i++) coef_act[i*COEF_W +: COEF_W] = act_coef[i];
  end

endmodule

// File: tb/tb_conv_coef_ctrl.sv
// Self-checking bench for conv_coef_ctrl: directed frame-swap scenarios plus
// random host traffic compared against a register-map level reference model.
module tb_conv_coef_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx_vs = 1'b0;
  logic         cfg_we = 1'b0;
  logic         cfg_re = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [7:0]   cfg_wdata = '0;
  logic [7:0]   cfg_rdata;
  logic         cfg_ready, cfg_err, armed, coef_upd;
  logic [199:0] coef_act;
  logic [3:0]   shift_act;

  int checks = 0;
  int errors = 0;

  conv_coef_ctrl dut (
    .clk(clk), .rst(rst), .rx_vs(rx_vs), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .armed(armed),
    .coef_act(coef_act), .shift_act(shift_act), .coef_upd(coef_upd)
  );

  always #5 clk = ~clk;

  // Reference model: register map contents plus commit bookkeeping.
  logic [7:0] pend_m [26];
  logic [7:0] act_m  [25];
  logic [3:0] act_sh_m;
  bit         armed_m, swap_m, vs_prev;
  logic [7:0] exp_rdata;
  bit         exp_err, exp_upd;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [199:0] act_vec();
    logic [199:0] v = '0;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = act_m[i];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [4:0] a);
    if (a <= 25) return pend_m[a];
    if (a == 26) return {armed_m, 7'b0};
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 26; i++) pend_m[i] = 8'h00;
    pend_m[12] = 8'd16;
    pend_m[25] = 8'd4;
    for (int i = 0; i < 25; i++) act_m[i] = pend_m[i];
    act_sh_m  = 4'd4;
    armed_m   = 0;
    swap_m    = 0;
    vs_prev   = 0;
    exp_rdata = 8'h00;
    exp_err   = 0;
    exp_upd   = 0;
  endtask

  task automatic check_all();
    check("coef_act",  coef_act,  act_vec());
    check("shift_act", shift_act, act_sh_m);
    check("armed",     armed,     armed_m);
    check("cfg_ready", cfg_ready, !armed_m && !swap_m);
    check("cfg_err",   cfg_err,   exp_err);
    check("coef_upd",  coef_upd,  exp_upd);
    check("cfg_rdata", cfg_rdata, exp_rdata);
  endtask

  // One clock cycle of host/video activity; the model applies the same event.
  task automatic step(input bit we, input bit re, input logic [4:0] addr,
                      input logic [7:0] wd, input bit vs);
    bit frame_start;
    @(negedge clk);
    cfg_we = we; cfg_re = re; cfg_addr = addr; cfg_wdata = wd; rx_vs = vs;
    frame_start = vs && !vs_prev;
    vs_prev = vs;
    if (re) exp_rdata = model_read(addr);
    exp_err = we && (addr >= 27 || (addr <= 25 && (armed_m || swap_m)));
    exp_upd = 0;
    if (swap_m) begin
      for (int i = 0; i < 25; i++) act_m[i] = pend_m[i];
      act_sh_m = pend_m[25][3:0];
      exp_upd  = 1;
      swap_m   = 0;
    end else if (armed_m) begin
      if (we && addr == 26 && wd[1]) armed_m = 0;
      else if (frame_start) begin
        armed_m = 0;
        swap_m  = 1;
      end
    end else if (we) begin
      if (addr <= 24) pend_m[addr] = wd;
      else if (addr == 25) pend_m[25] = wd & 8'h0F;
      else if (addr == 26 && wd[0]) armed_m = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit vs);
    @(negedge clk);
    rst = 1'b0;
    cfg_we = 0; cfg_re = 0; cfg_addr = '0; cfg_wdata = '0; rx_vs = vs;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit         vs_r = 0;
    logic [4:0] a;
    do_reset(0);

    for (int i = 0; i < 26; i++) step(0, 1, 5'(i), 8'h00, 0);
    check("id_tap12", coef_act[12*8 +: 8], 8'd16);

    // Commit holds through a long frame, swaps two cycles after VS rises.
    step(1, 0, 5'd0, 8'hF8, 0);
    step(1, 0, 5'd26, 8'h01, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 5'd0, 8'h00, 0);
    check("armed_wait", armed, 1'b1);
    step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 1);
    check("tap0_swapped", coef_act[7:0], 8'hF8);
    check("upd_pulse", coef_upd, 1'b1);
    step(0, 0, 5'd0, 8'h00, 1);

    // Rejected write while armed, readback, then abort beats the VS edge.
    step(0, 0, 5'd0, 8'h00, 0);
    step(1, 0, 5'd26, 8'h01, 0);
    step(1, 0, 5'd5, 8'h03, 0);
    step(0, 1, 5'd5, 8'h00, 0);
    step(1, 0, 5'd26, 8'h01, 0);
    step(1, 0, 5'd26, 8'h02, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 0);
    step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 1);

    // Commit on the same cycle VS rises waits for the next frame start.
    step(0, 0, 5'd0, 8'h00, 0);
    step(1, 0, 5'd25, 8'hA7, 0);
    step(1, 0, 5'd26, 8'h01, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 0);
    step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 1);
    check("shift_swapped", shift_act, 4'h7);

    // Reserved address.
    step(1, 0, 5'd30, 8'h55, 1);
    step(0, 1, 5'd30, 8'h00, 1);

    // Reset while armed discards the commit.
    step(1, 0, 5'd3, 8'h11, 0);
    step(1, 0, 5'd26, 8'h01, 0);
    do_reset(0);
    step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 1);
    step(0, 0, 5'd0, 8'h00, 1);

    // Random host traffic with sporadic frame starts.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) vs_r = ~vs_r;
      a = ($urandom_range(0, 9) < 2) ? 5'd26 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), a,
           8'($urandom), vs_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
